// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU, its multi-byte sequencer and benches.
// ALU_SEQ_SHIFT_EN (sequencer build option) enables multi-byte shift/rotate ops.
package alu_pkg;

    localparam logic [7:0] ALU_OP_NOP = 8'h00;
    localparam logic [7:0] ALU_OP_AND = 8'h01;
    localparam logic [7:0] ALU_OP_OR  = 8'h02;
    localparam logic [7:0] ALU_OP_XOR = 8'h03;
    localparam logic [7:0] ALU_OP_NOT = 8'h04;
    localparam logic [7:0] ALU_OP_ASL = 8'h11;
    localparam logic [7:0] ALU_OP_ROL = 8'h12;
    localparam logic [7:0] ALU_OP_ASR = 8'h13;
    localparam logic [7:0] ALU_OP_ROR = 8'h14;
    localparam logic [7:0] ALU_OP_ADD = 8'h21;
    localparam logic [7:0] ALU_OP_INC = 8'h22;
    localparam logic [7:0] ALU_OP_SUB = 8'h23;
    localparam logic [7:0] ALU_OP_DEC = 8'h24;
    localparam logic [7:0] ALU_OP_CMP = 8'h31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        CIN_REQ  = 2'd0,
        CIN_ZERO = 2'd1,
        CIN_ONE  = 2'd2
    } cin_sel_e;

    // op_first goes to the first byte issued, op_rest to every later byte.
    typedef struct packed {
        logic [7:0] op_first;
        logic [7:0] op_rest;
        logic       b_zero;
        cin_sel_e   cin_sel;
        logic       chain;
        logic       dir;
        logic       keep_a;
        logic       err;
    } opmap_t;

    function automatic logic cin_init(input cin_sel_e sel, input logic req_c);
        logic c;
        unique case (sel)
            CIN_ZERO: c = 1'b0;
            CIN_ONE:  c = 1'b1;
            default:  c = req_c;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_opmap.sv
// Decodes a multi-byte request opcode into per-byte ALU control.
// Shift/rotate ops decode only when ALU_SEQ_SHIFT_EN is defined.
module alu_seq_opmap
    import alu_pkg::*;
(
    input  logic [7:0] op_i,
    output opmap_t     map_o
);

    always_comb begin
        map_o.op_first = op_i;
        map_o.op_rest  = op_i;
        map_o.b_zero   = 1'b0;
        map_o.cin_sel  = CIN_REQ;
        map_o.chain    = 1'b1;
        map_o.dir      = 1'b0;
        map_o.keep_a   = 1'b0;
        map_o.err      = 1'b0;
        case (op_i)
            ALU_OP_ADD, ALU_OP_SUB: ;
            ALU_OP_INC: begin
                map_o.op_first = ALU_OP_ADD;
                map_o.op_rest  = ALU_OP_ADD;
                map_o.b_zero   = 1'b1;
                map_o.cin_sel  = CIN_ONE;
            end
            ALU_OP_DEC: begin
                map_o.op_first = ALU_OP_SUB;
                map_o.op_rest  = ALU_OP_SUB;
                map_o.b_zero   = 1'b1;
                map_o.cin_sel  = CIN_ZERO;
            end
            ALU_OP_CMP: begin
                map_o.op_first = ALU_OP_SUB;
                map_o.op_rest  = ALU_OP_SUB;
                map_o.cin_sel  = CIN_ONE;
                map_o.keep_a   = 1'b1;
            end
            ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR: begin
                map_o.chain = 1'b0;
            end
`ifdef ALU_SEQ_SHIFT_EN
            ALU_OP_ROL: ;
            ALU_OP_ROR: begin
                map_o.dir = 1'b1;
            end
            ALU_OP_ASL: begin
                map_o.op_first = ALU_OP_ROL;
                map_o.op_rest  = ALU_OP_ROL;
                map_o.cin_sel  = CIN_ZERO;
            end
            // Sign-fill only the top byte; lower bytes rotate its bit 0 down.
            ALU_OP_ASR: begin
                map_o.op_first = ALU_OP_ASR;
                map_o.op_rest  = ALU_OP_ROR;
                map_o.dir      = 1'b1;
            end
`endif
            default: begin
                map_o.op_first = ALU_OP_NOP;
                map_o.op_rest  = ALU_OP_NOP;
                map_o.chain    = 1'b0;
                map_o.err      = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-byte operation sequencer driving one byte-wide combinational ALU.
// ALU_SEQ_SHIFT_EN enables ROL/ROR/ASL/ASR (decoded in alu_seq_opmap).
module alu_seq
    import alu_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_op,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic                  req_carry,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_y,
    output logic                  rsp_carry,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [7:0]            alu_opcode,
    output logic                  alu_carry_in,
    input  logic [7:0]            alu_y,
    input  logic                  alu_carry_out
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    seq_state_e    state_q, state_d;
    logic [KW-1:0] k_q;
    logic [KW-1:0] idx;
    logic [W-1:0]  a_q, b_q, y_q;
    logic          carry_q;
    logic [7:0]    opf_q, opr_q;
    logic          chain_q, dir_q, keepa_q, err_q;
    logic          last;
    logic          done;
    opmap_t        map;

    alu_seq_opmap u_opmap (
        .op_i  (req_op),
        .map_o (map)
    );

    assign last = (k_q == KW'(NBYTES - 1));
    assign done = (state_q == ST_DONE);
    // dir is only ever set by the shift decode, so default builds count up.
    assign idx  = dir_q ? (KW'(NBYTES - 1) - k_q) : k_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_opcode   = ALU_OP_NOP;
        alu_carry_in = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    state_d = map.err ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_a        = a_q[8*int'(idx) +: 8];
                alu_b        = b_q[8*int'(idx) +: 8];
                alu_opcode   = (k_q == '0) ? opf_q : opr_q;
                alu_carry_in = carry_q;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            opf_q   <= ALU_OP_NOP;
            opr_q   <= ALU_OP_NOP;
            chain_q <= 1'b0;
            dir_q   <= 1'b0;
            keepa_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        k_q     <= '0;
                        a_q     <= req_a;
                        b_q     <= map.b_zero ? '0 : req_b;
                        // Error path reports operand A, so preload it.
                        y_q     <= req_a;
                        carry_q <= cin_init(map.cin_sel, req_carry);
                        opf_q   <= map.op_first;
                        opr_q   <= map.op_rest;
                        chain_q <= map.chain;
                        dir_q   <= map.dir;
                        keepa_q <= map.keep_a;
                        err_q   <= map.err;
                    end
                end
                ST_ISSUE: begin
                    y_q[8*int'(idx) +: 8] <= alu_y;
                    if (chain_q) begin
                        carry_q <= alu_carry_out;
                    end
                    k_q <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = done;
    assign rsp_y     = done ? (keepa_q ? a_q : y_q) : '0;
    assign rsp_carry = done & carry_q;
    assign rsp_zero  = done & (y_q == '0);
    assign rsp_err   = done & err_q;

endmodule
